riscv_uart_tx: RTL

//  Memory-mapped UART transmitter; the CPU-to-host counterpart of the UART programmer's receive path.

---
 rtl/riscv_uart_tx_pkg.sv | 34 +++
 rtl/riscv_uart_tx_if.sv | 27 ++
 rtl/riscv_sync_fifo.sv | 46 ++++
 rtl/riscv_uart_tx.sv | 125 ++++++++++++
 4 files changed

// File: rtl/riscv_uart_tx_pkg.sv
// rtl/riscv_uart_tx_pkg.sv - shared state encoding and status layout for the UART transmitter
package riscv_uart_tx_pkg;

    localparam int UART_TX_ST_LEN = 2;

    typedef enum logic [UART_TX_ST_LEN-1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_tx_state_e;

    // Bit positions of the TX status word as seen by software through the bridge
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_MSB   = 15;

    function automatic logic [15:0] uart_tx_status(input logic i_busy, input logic i_full,
                                                   input logic i_empty, input logic i_ovf,
                                                   input logic [7:0] i_count);
        logic [15:0] w_word;
        w_word                              = '0;
        w_word[STAT_BUSY_BIT]               = i_busy;
        w_word[STAT_FULL_BIT]               = i_full;
        w_word[STAT_EMPTY_BIT]              = i_empty;
        w_word[STAT_OVF_BIT]                = i_ovf;
        w_word[STAT_CNT_MSB:STAT_CNT_LSB]   = i_count;
        return w_word;
    endfunction

endpackage

// File: rtl/riscv_uart_tx_if.sv
// rtl/riscv_uart_tx_if.sv - bridge-side strobes and status of the UART transmitter
interface riscv_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             clr_ovf;
    logic             tx;
    logic             busy;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  tx, busy, fifo_full, fifo_empty, fifo_count, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output tx, busy, fifo_full, fifo_empty, fifo_count, overflow
    );

endinterface

// File: rtl/riscv_sync_fifo.sv
// rtl/riscv_sync_fifo.sv - single-clock FIFO with extra-bit pointers for full/empty/count
module riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_count  = r_wr_ptr - r_rd_ptr;
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (o_count == (AW+1)'(DEPTH));
    assign o_rdata  = r_mem[r_rd_ptr[AW-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/riscv_uart_tx.sv
// rtl/riscv_uart_tx.sv - memory-mapped 8N1 UART transmitter: FIFO, FSM, baud counter, shifter
module riscv_uart_tx
    import riscv_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            rst,
    riscv_uart_tx_if.slave  bus
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_tx_state_e    r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_overflow;

    logic              w_baud_end;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [7:0]        w_rd_data;
    logic              w_tx_next;

    riscv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.wr_en),
        .i_wdata (bus.wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_STOP && w_baud_end));

    // Line level follows the state one cycle later so tx is a clean flop output
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = r_shift[r_bit_idx];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_rd_data;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) r_state <= ST_STOP;
                        else                   r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_rd_data;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                                  r_overflow <= 1'b0;
        else if (bus.wr_en && w_full && !w_pop)    r_overflow <= 1'b1;
        else if (bus.clr_ovf)                      r_overflow <= 1'b0;
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_count = w_count;

endmodule
